// File: rtl/mips_pkg.sv
// Shared CPU state encoding, opcode/function constants and load/store classification helpers.
// Imported by the state sequencer and the instruction decoder.
package mips_pkg;

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        LOAD      = 3'd1,
        MEM       = 3'd2,
        LOAD_DATA = 3'd3,
        EXEC      = 3'd4,
        HALT      = 3'd5
    } cpu_state_t;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_LB    = 6'd32;
    localparam logic [5:0] OP_LH    = 6'd33;
    localparam logic [5:0] OP_LWL   = 6'd34;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_LBU   = 6'd36;
    localparam logic [5:0] OP_LHU   = 6'd37;
    localparam logic [5:0] OP_LWR   = 6'd38;
    localparam logic [5:0] OP_SB    = 6'd40;
    localparam logic [5:0] OP_SH    = 6'd41;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [5:0] FN_DIV   = 6'd26;
    localparam logic [5:0] FN_DIVU  = 6'd27;

    function automatic logic is_load(input logic [5:0] op);
        return (op >= OP_LB) && (op <= OP_LWR);
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mips_state_sequencer.sv
// Multi-cycle CPU sequencer: FETCH/LOAD/MEM/LOAD_DATA/EXEC/HALT with IR/PC strobes,
// halt detection and a retired-instruction counter. Optional divide stall: MIPS_SEQ_DIV_STALL_EN.
module mips_state_sequencer
    import mips_pkg::*;
#(
    parameter logic [31:0] HALT_ADDR = 32'h0,
    parameter int          CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 waitrequest,
    input  logic [5:0]           opcode,
    input  logic [5:0]           function_code,
    input  logic [31:0]          pc_next,
    input  logic                 div_done,
    output logic [2:0]           state,
    output logic                 ir_wren,
    output logic                 pc_wren,
    output logic                 mem_addr_sel,
    output logic                 active,
    output logic                 div_start,
    output logic [CNT_WIDTH-1:0] instr_count
);

    cpu_state_t           r_state;
    cpu_state_t           w_state_next;
    logic                 r_active;
    logic [CNT_WIDTH-1:0] r_instr_count;
    logic                 w_exec_done;
    logic                 w_div_start;

`ifdef MIPS_SEQ_DIV_STALL_EN
    logic r_div_busy;
    logic w_is_div;

    assign w_is_div    = (opcode == OP_RTYPE) &&
                         ((function_code == FN_DIV) || (function_code == FN_DIVU));
    // Launch only on the first EXEC cycle; a same-cycle div_done still completes the EXEC.
    assign w_div_start = (r_state == EXEC) && w_is_div && !r_div_busy;
    assign w_exec_done = !w_is_div || div_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div_busy <= 1'b0;
        end else if (r_state == EXEC) begin
            r_div_busy <= w_is_div && !w_exec_done;
        end else begin
            r_div_busy <= 1'b0;
        end
    end
`else
    logic w_unused_div;

    assign w_unused_div = &{1'b0, div_done, function_code};
    assign w_div_start  = 1'b0;
    assign w_exec_done  = 1'b1;
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            FETCH:     w_state_next = waitrequest ? FETCH : LOAD;
            LOAD:      w_state_next = (is_load(opcode) || is_store(opcode)) ? MEM : EXEC;
            MEM: begin
                if (!waitrequest) begin
                    w_state_next = is_load(opcode) ? LOAD_DATA : EXEC;
                end
            end
            LOAD_DATA: w_state_next = EXEC;
            EXEC: begin
                if (w_exec_done) begin
                    w_state_next = (pc_next == HALT_ADDR) ? HALT : FETCH;
                end
            end
            default:   w_state_next = HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= FETCH;
            r_active      <= 1'b1;
            r_instr_count <= '0;
        end else begin
            r_state  <= w_state_next;
            r_active <= (w_state_next != HALT);
            if ((r_state == EXEC) && w_exec_done) begin
                r_instr_count <= r_instr_count + 1'b1;
            end
        end
    end

    // Reset masks the strobes so nothing is written while the CPU is being reset.
    always_comb begin
        ir_wren      = 1'b0;
        pc_wren      = 1'b0;
        mem_addr_sel = 1'b0;
        div_start    = 1'b0;
        if (!reset) begin
            ir_wren      = (r_state == FETCH) && !waitrequest;
            mem_addr_sel = (r_state == MEM);
            pc_wren      = (r_state == EXEC) && w_exec_done;
            div_start    = w_div_start;
        end
    end

    assign state       = r_state;
    assign active      = r_active;
    assign instr_count = r_instr_count;

endmodule
